// File: rtl/link_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_scheduler
// Description : Shares one serial link transmitter among N frame requesters.
//               Round-robin arbitration, FW-bit frame capture, DATA_READY
//               handshake towards the transmitter and end-of-frame SYNC
//               tracking. All logic runs in the LINK_CLK domain.
// Revision    : 1.0 - initial release
//
// Optional feature macro:
//   LINK_TX_TIMEOUT_EN - adds a watchdog that abandons a frame stuck in
//                        ISSUE or WAIT_SYNC for TIMEOUT_CYC cycles and sets
//                        the sticky ERR flag. Without it ERR is tied to 0.
//
// Ports:
//   LINK_CLK       in   1        link clock, rising edge
//   RESETN         in   1        asynchronous active-low reset
//   REQ            in   N        per-requester request level, held until ACK
//   REQ_DATA       in   N*FW     requester i frame at [i*FW +: FW]
//   ACK            out  N        one-cycle pulse: frame captured
//   DONE           out  N        one-cycle pulse: frame fully transmitted
//   TX_READY       in   1        transmitter idle / able to accept a frame
//   TX_SYNC        in   1        transmitter end-of-frame pulse
//   TX_DATA_READY  out  1        frame-valid strobe to the transmitter
//   TX_DATA        out  [0:FW-1] registered frame (slice bit b -> TX_DATA[b])
//   BUSY           out  1        high whenever not IDLE
//   GRANT_ID       out  3        current or last granted requester
//   FRAME_CNT      out  CNT_W    completed frames, wraps
//   ERR            out  1        sticky watchdog error
// ============================================================================
module link_tx_scheduler #(
    parameter int N           = 4,
    parameter int FW          = 49,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               LINK_CLK,
    input  logic               RESETN,
    input  logic [N-1:0]       REQ,
    input  logic [N*FW-1:0]    REQ_DATA,
    output logic [N-1:0]       ACK,
    output logic [N-1:0]       DONE,
    input  logic               TX_READY,
    input  logic               TX_SYNC,
    output logic               TX_DATA_READY,
    output logic [0:FW-1]      TX_DATA,
    output logic               BUSY,
    output logic [2:0]         GRANT_ID,
    output logic [CNT_W-1:0]   FRAME_CNT,
    output logic               ERR
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_SYNC = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Elaboration-time guard on the supported configuration range.
    if (N < 2 || N > 8 || FW < 1 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("link_tx_scheduler: unsupported parameter value");
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [2:0]         rr_q,      rr_d;
    logic [2:0]         grant_q,   grant_d;
    logic [0:FW-1]      tx_data_q, tx_data_d;
    logic               tx_dv_q,   tx_dv_d;
    logic [N-1:0]       ack_q,     ack_d;
    logic [N-1:0]       done_q,    done_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    // ------------------------------------------------------------------------
    // Requester frame slices
    // ------------------------------------------------------------------------
    logic [FW-1:0] slices [N];

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign slices[g] = REQ_DATA[g*FW +: FW];
    end

    // ------------------------------------------------------------------------
    // Round-robin winner: first set REQ at or above the pointer, otherwise the
    // first set REQ below it (the wrap-around part of the scan).
    // ------------------------------------------------------------------------
    logic               win_found;
    logic [2:0]         win_idx;
    logic [N-1:0]       win_onehot;
    logic [FW-1:0]      win_slice;
    logic [0:FW-1]      win_frame;
    logic [N-1:0]       grant_onehot;
    logic [2:0]         rr_after_grant;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int j = 0; j < N; j++) begin
            if (!win_found && REQ[j] && (3'(j) >= rr_q)) begin
                win_found = 1'b1;
                win_idx   = 3'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!win_found && REQ[j]) begin
                win_found = 1'b1;
                win_idx   = 3'(j);
            end
        end
    end

    always_comb begin
        win_slice    = '0;
        win_onehot   = '0;
        grant_onehot = '0;
        for (int j = 0; j < N; j++) begin
            if (win_idx == 3'(j)) begin
                win_slice     = slices[j];
                win_onehot[j] = 1'b1;
            end
            if (grant_q == 3'(j)) begin
                grant_onehot[j] = 1'b1;
            end
        end
    end

    // Slice bit b is transmitted as TX_DATA[b]; TX_DATA is ascending, so an
    // explicit per-bit copy is needed rather than a whole-vector assignment.
    always_comb begin
        win_frame = '0;
        for (int b = 0; b < FW; b++) begin
            win_frame[b] = win_slice[b];
        end
    end

    // The requester that just finished drops to the lowest priority.
    assign rr_after_grant = (grant_q == 3'(N-1)) ? 3'd0 : grant_q + 3'd1;

`ifdef LINK_TX_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q,  err_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        tx_dv_d   = tx_dv_q;
        ack_d     = '0;
        done_d    = '0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // TX_READY low also covers the transmitter's post-reset warm-up.
                if (TX_READY && win_found) begin
                    tx_data_d = win_frame;
                    tx_dv_d   = 1'b1;
                    ack_d     = win_onehot;
                    grant_d   = win_idx;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // TX_READY falling is the transmitter's acceptance of the frame.
                if (!TX_READY) begin
                    tx_dv_d = 1'b0;
                    state_d = ST_WAIT_SYNC;
                end
            end

            ST_WAIT_SYNC: begin
                if (TX_SYNC) begin
                    done_d  = grant_onehot;
                    cnt_d   = cnt_q + CNT_ONE;
                    rr_d    = rr_after_grant;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                tx_dv_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

`ifdef LINK_TX_TIMEOUT_EN
        err_d  = err_q;
        wdog_d = '0;
        // Counter restarts on every state entry and only runs while the
        // scheduler is parked in ISSUE or WAIT_SYNC.
        if ((state_q == ST_ISSUE || state_q == ST_WAIT_SYNC) && (state_d == state_q)) begin
            if (wdog_q == WD_LAST) begin
                err_d   = 1'b1;
                tx_dv_d = 1'b0;
                rr_d    = rr_after_grant;
                state_d = ST_IDLE;
            end else begin
                wdog_d = wdog_q + WD_ONE;
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge LINK_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            rr_q      <= 3'd0;
            grant_q   <= 3'd0;
            tx_data_q <= '0;
            tx_dv_q   <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            tx_dv_q   <= tx_dv_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef LINK_TX_TIMEOUT_EN
    always_ff @(posedge LINK_CLK or negedge RESETN) begin
        if (!RESETN) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ACK           = ack_q;
    assign DONE          = done_q;
    assign TX_DATA_READY = tx_dv_q;
    assign TX_DATA       = tx_data_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign GRANT_ID      = grant_q;
    assign FRAME_CNT     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_link_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_tx_scheduler
// Description : Directed self-checking bench for link_tx_scheduler. The bench
//               plays the requesters and the transmitter (TX_READY / TX_SYNC)
//               cycle by cycle with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_tx_scheduler;

    localparam int N     = 4;
    localparam int FW    = 49;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic [N-1:0]       req;
    logic [N*FW-1:0]    req_data;
    logic [N-1:0]       ack;
    logic [N-1:0]       done;
    logic               tx_ready;
    logic               tx_sync;
    logic               tx_data_ready;
    logic [0:FW-1]      tx_data;
    logic               busy;
    logic [2:0]         grant_id;
    logic [CNT_W-1:0]   frame_cnt;
    logic               err;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] pat [N];

    always #5 clk = ~clk;

    assign req_data = {pat[3], pat[2], pat[1], pat[0]};

    link_tx_scheduler #(
        .N(N), .FW(FW), .CNT_W(CNT_W), .TIMEOUT_CYC(64)
    ) dut (
        .LINK_CLK      (clk),
        .RESETN        (resetn),
        .REQ           (req),
        .REQ_DATA      (req_data),
        .ACK           (ack),
        .DONE          (done),
        .TX_READY      (tx_ready),
        .TX_SYNC       (tx_sync),
        .TX_DATA_READY (tx_data_ready),
        .TX_DATA       (tx_data),
        .BUSY          (busy),
        .GRANT_ID      (grant_id),
        .FRAME_CNT     (frame_cnt),
        .ERR           (err)
    );

    // Expected transmitter frame: slice bit b appears at TX_DATA[b].
    function automatic logic [0:FW-1] map_frame(input logic [FW-1:0] s);
        logic [0:FW-1] r;
        for (int b = 0; b < FW; b++) r[b] = s[b];
        return r;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        req      = '0;
        tx_ready = 1'b0;
        tx_sync  = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic early;
        resetn   = 1'b0;
        req      = 4'b0001;
        tx_ready = 1'b0;
        tx_sync  = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ack, done, tx_data_ready, busy, grant_id, frame_cnt, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b done=%b dv=%b busy=%b gid=%0d cnt=%0d err=%b want all 0",
                     ack, done, tx_data_ready, busy, grant_id, frame_cnt, err);
        end
        checks++;
        if (tx_data !== '0) begin
            errors++;
            $display("FAIL reset_tx_data got %h want 0", tx_data);
        end
        resetn = 1'b1;
        early  = 1'b0;
        for (int c = 0; c < 49; c++) begin
            tick();
            if (ack !== '0 || tx_data_ready !== 1'b0 || busy !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL warmup_no_grant got early=%b want 0", early);
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0001 || tx_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL warmup_grant got ack=%b dv=%b want ack=0001 dv=1", ack, tx_data_ready);
        end
        checks++;
        if (tx_data !== map_frame(pat[0])) begin
            errors++;
            $display("FAIL warmup_tx_data got %h want %h", tx_data, map_frame(pat[0]));
        end
        req      = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        tx_sync = 1'b1;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        checks++;
        if (done !== 4'b0001 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL warmup_done got done=%b cnt=%0d want done=0001 cnt=1", done, frame_cnt);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [N-1:0] oh;
        do_reset();
        tx_ready = 1'b1;
        req      = 4'b1111;
        for (int k = 0; k < N; k++) begin
            oh = 4'b0001 << k;
            tick();
            checks++;
            if (ack !== oh || grant_id !== 3'(k) || tx_data_ready !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant_%0d got ack=%b gid=%0d dv=%b want ack=%b gid=%0d dv=1",
                         k, ack, grant_id, tx_data_ready, oh, k);
            end
            checks++;
            if (tx_data !== map_frame(pat[k])) begin
                errors++;
                $display("FAIL rr_data_%0d got %h want %h", k, tx_data, map_frame(pat[k]));
            end
            // Transmitter not yet taking the frame; spurious SYNC must be ignored.
            tx_sync = 1'b1;
            tick();
            tx_sync = 1'b0;
            checks++;
            if (tx_data_ready !== 1'b1 || ack !== '0 || done !== '0 || tx_data !== map_frame(pat[k])) begin
                errors++;
                $display("FAIL rr_hold_%0d got dv=%b ack=%b done=%b want dv=1 ack=0 done=0 data stable",
                         k, tx_data_ready, ack, done);
            end
            tx_ready = 1'b0;
            tick();
            checks++;
            if (tx_data_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_taken_%0d got dv=%b busy=%b want dv=0 busy=1", k, tx_data_ready, busy);
            end
            tick();
            tx_sync = 1'b1;
            tick();
            tx_sync  = 1'b0;
            tx_ready = 1'b1;
            if (k == N-1) req = '0;
            checks++;
            if (done !== oh || frame_cnt !== 16'(k + 1)) begin
                errors++;
                $display("FAIL rr_done_%0d got done=%b cnt=%0d want done=%b cnt=%0d",
                         k, done, frame_cnt, oh, k + 1);
            end
        end
        tick();
        checks++;
        if (frame_cnt !== 16'd4 || grant_id !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_final got cnt=%0d gid=%0d busy=%b want cnt=4 gid=3 busy=0",
                     frame_cnt, grant_id, busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_withdraw();
        logic stray;
        do_reset();
        tx_ready = 1'b1;
        req      = 4'b0001;
        tick();
        tx_ready = 1'b0;
        req      = '0;
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL withdraw_no_ack got ack=%b want 0000", ack);
        end
        tick();
        tx_sync = 1'b1;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        checks++;
        if (done !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_done got done=%b busy=%b want done=0001 busy=0", done, busy);
        end
        stray = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack !== '0 || busy !== 1'b0 || grant_id !== 3'd0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle got stray=%b want 0", stray);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sync_and_req();
        do_reset();
        tx_ready = 1'b1;
        req      = 4'b1000;
        tick();
        tx_ready = 1'b0;
        req      = '0;
        tick();
        tick();
        tx_sync = 1'b1;
        req     = 4'b0010;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        checks++;
        if (done !== 4'b1000 || ack !== '0) begin
            errors++;
            $display("FAIL syncreq_done_first got done=%b ack=%b want done=1000 ack=0000", done, ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0010 || grant_id !== 3'd1) begin
            errors++;
            $display("FAIL syncreq_grant got ack=%b gid=%0d want ack=0010 gid=1", ack, grant_id);
        end
        // Requester 1 keeps REQ up; requester 0 joins. After 1 finishes the
        // pointer sits at 2, so 0 must win over 1.
        req      = 4'b0011;
        tx_ready = 1'b0;
        tick();
        tx_sync = 1'b1;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0001 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL syncreq_lowprio got ack=%b gid=%0d want ack=0001 gid=0", ack, grant_id);
        end
        req      = '0;
        tx_ready = 1'b0;
        tick();
        tx_sync = 1'b1;
        tick();
        tx_sync = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_frame();
        do_reset();
        tx_ready = 1'b1;
        req      = 4'b0001;
        tick();
        tx_ready = 1'b0;
        req      = '0;
        tick();
        tx_sync = 1'b1;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        req      = 4'b0100;
        tick();
        tx_ready = 1'b0;
        req      = '0;
        tick();
        checks++;
        if (busy !== 1'b1 || grant_id !== 3'd2 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_pre got busy=%b gid=%0d cnt=%0d want busy=1 gid=2 cnt=1",
                     busy, grant_id, frame_cnt);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({ack, done, tx_data_ready, busy, grant_id, frame_cnt, err} !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL midreset_async got busy=%b gid=%0d cnt=%0d dv=%b data=%h want all 0",
                     busy, grant_id, frame_cnt, tx_data_ready, tx_data);
        end
        tx_sync = 1'b1;
        tick();
        tx_sync = 1'b0;
        resetn  = 1'b1;
        checks++;
        if (done !== '0) begin
            errors++;
            $display("FAIL midreset_no_done got done=%b want 0000", done);
        end
        tick();
        checks++;
        if (done !== '0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_after got done=%b busy=%b cnt=%0d want 0 0 0", done, busy, frame_cnt);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_watchdog();
        logic early;
        do_reset();
        tx_ready = 1'b1;
        req      = 4'b0001;
        tick();
        tx_ready = 1'b0;
        req      = '0;
        tick();
        req   = 4'b0010;
        early = 1'b0;
        for (int c = 0; c < 63; c++) begin
            tick();
            if (err !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL wdog_before_limit got early=%b want 0", early);
        end
        tick();
`ifdef LINK_TX_TIMEOUT_EN
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== '0 || tx_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL wdog_fire got err=%b busy=%b done=%b dv=%b want err=1 busy=0 done=0 dv=0",
                     err, busy, done, tx_data_ready);
        end
        tick();
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL wdog_wait_ready got ack=%b want 0000", ack);
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0010 || err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_next got ack=%b err=%b want ack=0010 err=1", ack, err);
        end
`else
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wdog_absent got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        tx_sync = 1'b1;
        tick();
        tx_sync  = 1'b0;
        tx_ready = 1'b1;
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL wdog_late_sync got done=%b want 0001", done);
        end
        tick();
        checks++;
        if (ack !== 4'b0010 || grant_id !== 3'd1) begin
            errors++;
            $display("FAIL wdog_next got ack=%b gid=%0d want ack=0010 gid=1", ack, grant_id);
        end
`endif
        req = '0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        pat[0] = 49'h1_0000_0000_0003;
        pat[1] = 49'h0_ABCD_1234_5678;
        pat[2] = 49'h1_5555_AAAA_0F0F;
        pat[3] = 49'h0_0F00_FF00_C3A5;
        resetn   = 1'b0;
        req      = '0;
        tx_ready = 1'b0;
        tx_sync  = 1'b0;

        test_reset();
        test_round_robin();
        test_withdraw();
        test_sync_and_req();
        test_reset_mid_frame();
        test_watchdog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
